// File: rtl/nrzi_tx.sv
// nrzi_tx -- parallel-to-serial NRZI line encoder.
//
// Accepts bytes over a valid/ready handshake into a one-entry holding buffer,
// serializes them LSB first, and NRZI-encodes each bit: a 0 bit toggles the
// line, a 1 bit holds it. Each bit lasts CLKS_PER_BIT clk cycles. A byte
// waiting in the buffer is loaded at the end of the previous byte's last bit,
// so streamed bytes are sent back to back without gap cycles.
//
// Build option: define NRZI_TX_STUFF_EN to insert one stuffed 0 bit after
// every run of six consecutive data 1 bits. The run is counted across byte
// boundaries. Without the macro, every byte takes exactly 8 bit periods.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit period (>= 1)
//   IDLE_LEVEL    line_out level after reset
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   tx_data   byte to transmit
//   tx_valid  tx_data is valid
//   tx_ready  holding buffer is empty and can accept a byte
//   line_out  NRZI-encoded serial line
//   line_oe   high while bits are being driven
//   busy      a byte is in the shifter or the buffer, or a stuff bit is pending
module nrzi_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic        IDLE_LEVEL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       line_out,
  output logic       line_oe,
  output logic       busy
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

`ifdef NRZI_TX_STUFF_EN
  typedef enum logic [1:0] {IDLE, SEND, STUFF} state_t;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif

  state_t          state_q, state_d;
  logic [7:0]      buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  // Bit 0 goes straight from the buffer to the line at load time, so the
  // shifter only keeps the remaining seven bits.
  logic [6:0]      shift_q, shift_d;
  logic [2:0]      idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            line_q, line_d;
  logic            oe_q, oe_d;
`ifdef NRZI_TX_STUFF_EN
  logic [2:0]      ones_q, ones_d;
  logic            stuff_go;
`endif

  logic bit_end, boundary, load, advance, start, go_idle, nbit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      line_q     <= IDLE_LEVEL;
      oe_q       <= 1'b0;
`ifdef NRZI_TX_STUFF_EN
      ones_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      line_q     <= line_d;
      oe_q       <= oe_d;
`ifdef NRZI_TX_STUFF_EN
      ones_q     <= ones_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    line_d     = line_q;
    oe_d       = oe_q;
`ifdef NRZI_TX_STUFF_EN
    ones_d     = ones_q;
    stuff_go   = 1'b0;
`endif
    boundary   = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    start      = 1'b0;
    go_idle    = 1'b0;
    nbit       = 1'b0;

    bit_end = (timer_q == T_LAST);

    if (state_q != IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      IDLE: load = buf_full_q;
      SEND: begin
        if (bit_end) begin
          boundary = 1'b1;
`ifdef NRZI_TX_STUFF_EN
          if (ones_q == 3'd6) begin
            stuff_go = 1'b1;
            boundary = 1'b0;
          end
`endif
        end
      end
`ifdef NRZI_TX_STUFF_EN
      STUFF: boundary = bit_end;
`endif
      default: ;
    endcase

    // End of a data or stuff bit period: next bit, next byte, or idle.
    if (boundary) begin
      if (idx_q != 3'd7) begin
        advance = 1'b1;
      end else if (buf_full_q) begin
        load = 1'b1;
      end else begin
        go_idle = 1'b1;
      end
    end

    if (load) begin
      shift_d    = buf_q[7:1];
      idx_d      = '0;
      nbit       = buf_q[0];
      buf_full_d = 1'b0;
      start      = 1'b1;
    end else if (advance) begin
      shift_d = {1'b0, shift_q[6:1]};
      idx_d   = idx_q + 3'd1;
      nbit    = shift_q[0];
      start   = 1'b1;
    end

    if (start) begin
      state_d = SEND;
      timer_d = '0;
      oe_d    = 1'b1;
      line_d  = nbit ? line_q : ~line_q;
`ifdef NRZI_TX_STUFF_EN
      ones_d  = nbit ? ones_q + 3'd1 : '0;
`endif
    end

`ifdef NRZI_TX_STUFF_EN
    if (stuff_go) begin
      state_d = STUFF;
      timer_d = '0;
      line_d  = ~line_q;
      ones_d  = '0;
    end
`endif

    if (go_idle) begin
      state_d = IDLE;
      timer_d = '0;
      oe_d    = 1'b0;
`ifdef NRZI_TX_STUFF_EN
      ones_d  = '0;
`endif
    end

    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    tx_ready = ~buf_full_q;
    busy     = (state_q != IDLE) | buf_full_q;
    line_out = line_q;
    line_oe  = oe_q;
  end

endmodule

// File: tb/tb_nrzi_tx.sv
// tb_nrzi_tx -- directed bench for nrzi_tx with hand-computed line levels.
// Two instances: CLKS_PER_BIT=4 and CLKS_PER_BIT=1. The sampled line is also
// decoded (NRZI receive with stuff removal when NRZI_TX_STUFF_EN is defined)
// and compared against the bytes sent.
module tb_nrzi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d4, d1;
  logic       v4, v1;
  logic       rdy4, line4, oe4, busy4;
  logic       rdy1, line1, oe1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nrzi_tx #(.CLKS_PER_BIT(4), .IDLE_LEVEL(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .tx_data(d4), .tx_valid(v4), .tx_ready(rdy4),
    .line_out(line4), .line_oe(oe4), .busy(busy4)
  );

  nrzi_tx #(.CLKS_PER_BIT(1), .IDLE_LEVEL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
    .line_out(line1), .line_oe(oe1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v4  = 1'b0;
    v1  = 1'b0;
    #1;
    check("rst line4", line4, 1);
    check("rst oe4", oe4, 0);
    check("rst rdy4", rdy4, 1);
    check("rst busy4", busy4, 0);
    check("rst line1", line1, 1);
    check("rst oe1", oe1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input bit hold);
    int w = 0;
    while (((sel ? rdy1 : rdy4) !== 1'b1) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL send ready timeout: got 0 expected 1");
    end
    if (sel) begin d1 = b; v1 = 1'b1; end
    else     begin d4 = b; v4 = 1'b1; end
    @(posedge clk);
    #1;
    check("lat oe", sel ? oe1 : oe4, 0);
    check("lat rdy", sel ? rdy1 : rdy4, 0);
    check("lat busy", sel ? busy1 : busy4, 1);
    if (!hold) begin
      if (sel) v1 = 1'b0;
      else     v4 = 1'b0;
    end
  endtask

  // Called right after the accepting edge E0; sample s is taken at the
  // negedge following edge E(s+1). tx_ready is expected low for samples
  // rlo_from..rlo_to and high otherwise.
  task automatic run_line(input bit sel, input string tag, input logic [31:0] lv,
                          input int nper, input int cpb, input logic endlvl,
                          input int rlo_from, input int rlo_to,
                          input logic [15:0] exp_data, input int nbits);
    logic        prev = 1'b1;
    logic        lvl;
    logic        b;
    logic        stuffed;
    int          run = 0;
    int          k = 0;
    logic [15:0] dec = '0;
    for (int p = 0; p < nper; p++) begin
      for (int c = 0; c < cpb; c++) begin
        int s;
        s = p * cpb + c;
        @(posedge clk);
        @(negedge clk);
        lvl = sel ? line1 : line4;
        check($sformatf("%s line s%0d", tag, s), lvl, lv[p]);
        check($sformatf("%s oe s%0d", tag, s), sel ? oe1 : oe4, 1);
        check($sformatf("%s busy s%0d", tag, s), sel ? busy1 : busy4, 1);
        check($sformatf("%s rdy s%0d", tag, s), sel ? rdy1 : rdy4,
              (s >= rlo_from && s <= rlo_to) ? 0 : 1);
        if (c == 0) begin
          b = (lvl === prev);
          prev = lvl;
          stuffed = 1'b0;
`ifdef NRZI_TX_STUFF_EN
          stuffed = (run == 6);
`endif
          if (stuffed) begin
            check($sformatf("%s stuff p%0d", tag, p), b, 0);
            run = 0;
          end else begin
            if (k < 16) dec[k] = b;
            k++;
            run = b ? run + 1 : 0;
          end
        end
      end
    end
    check({tag, " nbits"}, k, nbits);
    check({tag, " decode"}, dec, exp_data);
    @(posedge clk);
    @(negedge clk);
    check({tag, " idle oe"}, sel ? oe1 : oe4, 0);
    check({tag, " idle line"}, sel ? line1 : line4, endlvl);
    check({tag, " idle busy"}, sel ? busy1 : busy4, 0);
    check({tag, " idle rdy"}, sel ? rdy1 : rdy4, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    v4 = 1'b0; v1 = 1'b0;
    d4 = '0;   d1 = '0;

    // Single 0x00: every bit toggles.
    do_reset();
    send(0, 8'h00, 0);
    run_line(0, "b00", 32'hAA, 8, 4, 1'b1, 1, 0, 16'h0000, 8);

    // Single 0xFF: run of ones, stuffed when enabled.
    do_reset();
    send(0, 8'hFF, 0);
`ifdef NRZI_TX_STUFF_EN
    run_line(0, "bFF", 32'h03F, 9, 4, 1'b0, 1, 0, 16'h00FF, 8);
`else
    run_line(0, "bFF", 32'hFF, 8, 4, 1'b1, 1, 0, 16'h00FF, 8);
`endif

    // Stream 0xA5, 0x3C with tx_valid held high.
    do_reset();
    send(0, 8'hA5, 1);
    d4 = 8'h3C;
    fork
      run_line(0, "strm", 32'hBEC9, 16, 4, 1'b1, 1, 31, 16'h3CA5, 16);
      begin
        @(posedge clk);
        @(posedge clk);
        #1 v4 = 1'b0;
      end
    join

    // Stream 0xF0, 0x03: ones run spans the byte boundary.
    do_reset();
    send(0, 8'hF0, 1);
    d4 = 8'h03;
    fork
`ifdef NRZI_TX_STUFF_EN
      run_line(0, "bnd", 32'h0ABFA, 17, 4, 1'b0, 1, 31, 16'h03F0, 16);
`else
      run_line(0, "bnd", 32'hABFA, 16, 4, 1'b1, 1, 31, 16'h03F0, 16);
`endif
      begin
        @(posedge clk);
        @(posedge clk);
        #1 v4 = 1'b0;
      end
    join

    // Reset during bit 3 of 0x55, then a clean 0x00.
    do_reset();
    send(0, 8'h55, 0);
    repeat (13) @(posedge clk);
    #2;
    check("abort pre oe", oe4, 1);
    rst = 1'b1;
    #1;
    check("abort line", line4, 1);
    check("abort oe", oe4, 0);
    check("abort rdy", rdy4, 1);
    check("abort busy", busy4, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("post oe c%0d", i), oe4, 0);
      check($sformatf("post line c%0d", i), line4, 1);
      check($sformatf("post busy c%0d", i), busy4, 0);
    end
    send(0, 8'h00, 0);
    run_line(0, "rb00", 32'hAA, 8, 4, 1'b1, 1, 0, 16'h0000, 8);

    // CLKS_PER_BIT=1, 0x01.
    do_reset();
    send(1, 8'h01, 0);
    run_line(1, "c1", 32'h55, 8, 1, 1'b0, 1, 0, 16'h0001, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nrzi_tx.md
Name: nrzi_tx

Overview:
- Parallel-to-serial NRZI line encoder. It is the transmit counterpart of the team's NRZI receive/decode flop stage.
- Accepts bytes over a valid/ready handshake and serializes them LSB first.
- Encodes each bit as NRZI: a 0 bit toggles the line, a 1 bit holds the line level.
- Optionally inserts bit-stuffing after runs of ones. Sits between packet logic and the serial pad driver.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit period; legal range ≥1; the bit-timer width is the clog2 of this value.
- IDLE_LEVEL, 1'b1, line_out level after reset.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- tx_data  input  8  byte to transmit
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  one-entry holding buffer is empty and can accept a byte
- line_out  output  1  NRZI-encoded serial line
- line_oe  output  1  line output enable; high while bits are being driven
- busy  output  1  a byte is in the shifter, the buffer, or a stuff bit is pending

Behaviour:
- Reset (async, any state) puts the block in this state:
  - state=IDLE, buffer empty, shifter cleared, bit timer=0, bit index=0, ones counter=0.
  - line_out=IDLE_LEVEL, line_oe=0, tx_ready=1, busy=0.
- Reset mid-byte aborts the transfer immediately. No partial bits or stuff bits are sent afterwards.
- Handshake:
  - A byte is accepted on any rising edge where tx_valid && tx_ready. It is captured into the holding buffer.
  - tx_ready = ~buffer_full (registered state, no combinational path from tx_valid).
  - Back-to-back streaming: the buffer may refill while the shifter is sending.
- States:
  - IDLE: at the first edge with buffer full, move buffer→shifter (buffer empties), set bit_idx=0, go to SEND. Drive bit0 on the same edge and set line_oe=1.
    - Latency: a byte accepted at edge E0 puts bit0 on the line at edge E1.
  - SEND: each bit is held CLKS_PER_BIT cycles. At the end of a bit period (timer wraps):
    - if a stuff bit is required (see Optional Feature), go to STUFF;
    - else if bit_idx<7, advance to the next bit;
    - else if bit_idx==7 and buffer full, reload the shifter from the buffer and drive its bit0 at the same edge (no gap cycles);
    - else if bit_idx==7 and buffer empty, go to IDLE.
  - STUFF: drive one 0 bit (toggle line) for CLKS_PER_BIT cycles, clear the ones counter, then resume the same decision at the byte boundary or next bit.
  - Entering IDLE: line_oe←0 and line_out holds its last level.
- NRZI encoding: at each bit start, line_out←~line_out for a 0 bit and stays unchanged for a 1 bit.
- Ones counter:
  - Increments on each data 1 bit and clears on a data 0 bit or a stuffed bit.
  - Carries across byte boundaries within one stream.
  - Clears on IDLE entry.
- busy = (state!=IDLE) | buffer_full.
- A simultaneous accept and shifter reload at the same edge is legal: the buffer ends full with the new byte.

Optional Feature:
- Macro: NRZI_TX_STUFF_EN.
- Defined: after the 6th consecutive data 1 bit completes, one stuffed 0 bit is inserted. This applies even if that 1 is the final bit of the stream, in which case STUFF runs before IDLE.
- Undefined: STUFF state and ones counter are not built. Bits are sent unmodified, so a byte always takes exactly 8 bit periods.

Test Plan:
- Reset then send 0x00 (CLKS_PER_BIT=4): line_out levels per bit = 0,1,0,1,0,1,0,1; each level held 4 clks; line_oe high for 32 clks, then low with line_out=1.
- Send 0xFF with NRZI_TX_STUFF_EN: line held 1 for 6 bit periods, stuffed bit drives 0, last two ones hold 0; 9 bit periods total, line_oe high 36 clks. Without the macro: line stays 1 for 8 periods (32 clks).
- Stream 0xA5 then 0x3C with tx_valid held high:
  - second byte accepted while the first is shifting;
  - tx_ready drops for exactly the buffer-full interval;
  - second byte's bit0 starts the clk immediately after the first byte's bit7 period, with no gap;
  - decoding the line with the team's NRZI receive stage returns 0xA5, 0x3C.
- Stuffing across a boundary (macro on): send 0xF0 then 0x03. The ones run is 4+2; stuff is inserted after bit1 of the second byte. Decoded stream with stuff removed matches the input.
- Assert rst during bit 3 of 0x55: line_out=1 and line_oe=0 immediately (async), tx_ready=1. A following 0x00 is sent cleanly starting from level 1.
- CLKS_PER_BIT=1, send 0x01: bit0 (value 1) holds line_out=1 for 1 clk, then 7 zeros toggle every clk (0,1,0,1,0,1,0); idle after 8 clks.
